// File: rtl/execute_md_stage_pkg.sv
// +--------------------------------------------------------------------------+
// | execute_md_stage_pkg : shared types for the EX stage and its M unit      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package execute_md_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_t;

  typedef enum logic [1:0] {
    EX_OUT_ALU    = 2'd0,
    EX_OUT_IMM    = 2'd1,
    EX_OUT_PC_INC = 2'd2
  } execute_mux_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [2:0] mem_type;
    logic [1:0] wb_src_sel;
    logic       hlt;
    logic [4:0] rd;
    logic [4:0] rs2;
  } ex_ctrl_t;

  // A bubble keeps the bundle but drops every architectural side effect.
  function automatic ex_ctrl_t bubble_ctrl(input ex_ctrl_t c);
    ex_ctrl_t b;
    b           = c;
    b.reg_write = 1'b0;
    b.mem_write = 1'b0;
    b.mem_read  = 1'b0;
    b.hlt       = 1'b0;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/execute_md_stage_md_iter.sv
// +--------------------------------------------------------------------------+
// | md_iter : iterative RV32M engine (shift-add MUL, restoring DIV)          |
// | Build option MD_EARLY_OUT_EN: finish MUL once the multiplier is zero.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module md_iter
  import execute_md_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic            freeze,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              MUL_ITERS = XLEN / MUL_BITS;
  localparam int              CNT_W     = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_q, state_d;
  md_op_t            op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              negp_q, negp_d;
  logic              negr_q, negr_d;

  logic              a_neg, b_neg, div_ovf, mul_early, div_ge;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] partial, prod_s;
  logic [XLEN:0]     r_sh, r_sub;

  always_comb begin
    a_neg   = (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && a[XLEN-1];
    b_neg   = (op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}) && b[XLEN-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    div_ovf = (op inside {MD_DIV, MD_REM}) && (a == MIN_VAL) && (b == '1);
    partial = mcand_q * {{(2*XLEN-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};
    r_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge  = r_sh >= {1'b0, mcand_q[XLEN-1:0]};
    r_sub   = r_sh - {1'b0, mcand_q[XLEN-1:0]};
  end

`ifdef MD_EARLY_OUT_EN
  // Checked before each iteration except the first, so at least one runs.
  assign mul_early = (cnt_q != '0) && (mplier_q == '0);
`else
  assign mul_early = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    negp_d   = negp_q;
    negr_d   = negr_q;
    if (!freeze) begin
      if (flush) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              op_d   = op;
              cnt_d  = '0;
              negp_d = a_neg ^ b_neg;
              negr_d = a_neg;
              if (op[2]) begin
                mcand_d = {{XLEN{1'b0}}, b_mag};
                acc_d   = {{XLEN{1'b0}}, a_mag};
                if (b == '0) begin
                  // Remainder half carries the raw dividend, quotient all ones.
                  acc_d   = {a, {XLEN{1'b1}}};
                  negp_d  = 1'b0;
                  negr_d  = 1'b0;
                  state_d = ST_DONE;
                end else if (div_ovf) begin
                  acc_d   = {{XLEN{1'b0}}, MIN_VAL};
                  negp_d  = 1'b0;
                  negr_d  = 1'b0;
                  state_d = ST_DONE;
                end else begin
                  state_d = ST_DIV;
                end
              end else begin
                mcand_d  = {{XLEN{1'b0}}, a_mag};
                mplier_d = b_mag;
                acc_d    = '0;
                state_d  = ST_MUL;
              end
            end
          end
          ST_MUL: begin
            if (mul_early) begin
              state_d = ST_DONE;
            end else begin
              acc_d    = acc_q + partial;
              mcand_d  = mcand_q << MUL_BITS;
              mplier_d = mplier_q >> MUL_BITS;
              cnt_d    = cnt_q + 1'b1;
              if (cnt_q == CNT_W'(MUL_ITERS - 1)) state_d = ST_DONE;
            end
          end
          ST_DIV: begin
            acc_d = div_ge ? {r_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                           : {r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_DONE;
          end
          ST_DONE: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    prod_s = negp_q ? -acc_q : acc_q;
    case (op_q)
      MD_MUL:          result = prod_s[XLEN-1:0];
      MD_DIV, MD_DIVU: result = negp_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      MD_REM, MD_REMU: result = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      default:         result = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign stall = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                 ((state_q == ST_IDLE) && start && !flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      negp_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      negp_q   <= negp_d;
      negr_q   <= negr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/execute_md_stage.sv
// +--------------------------------------------------------------------------+
// | execute_md_stage : EX stage (forwarding, ALU, EX/MEM) with RV32M unit    |
// | Build option MD_EARLY_OUT_EN is consumed by md_iter.   Rev 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module execute_md_stage
  import execute_md_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_ex_valid,
  input  ex_ctrl_t        id_ex_ctrl,
  input  alu_t            id_ex_alu_op,
  input  logic            id_ex_md_en,
  input  md_op_t          id_ex_md_op,
  input  logic            id_ex_alu_a_src,
  input  logic            id_ex_alu_b_src,
  input  logic [4:0]      id_ex_shamt,
  input  execute_mux_t    id_ex_ex_out_sel,
  input  logic [XLEN-1:0] id_ex_sra,
  input  logic [XLEN-1:0] id_ex_srb,
  input  logic [XLEN-1:0] id_ex_imm32,
  input  logic [XLEN-1:0] id_ex_pc,
  input  logic [XLEN-1:0] id_ex_pc_inc,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ext_stall,
  input  logic            ex_flush,
  output logic            ex_stall_req,
  output logic            md_busy,
  output logic [XLEN-1:0] ex_mem_execute_out,
  output logic [XLEN-1:0] ex_mem_mem_data_in,
  output logic [XLEN-1:0] ex_mem_pc,
  output ex_ctrl_t        ex_mem_ctrl
);

  logic [XLEN-1:0] execute_out_q, execute_out_d;
  logic [XLEN-1:0] mem_data_q, mem_data_d;
  logic [XLEN-1:0] pc_q, pc_d;
  ex_ctrl_t        ctrl_q, ctrl_d;

  logic [XLEN-1:0] op_a_fwd, op_b_fwd, alu_a, alu_b, alu_res, ex_out, md_result;
  logic [4:0]      shamt;
  logic            md_stall, md_done;

  always_comb begin
    op_a_fwd = fwd_a[1] ? execute_out_q : (fwd_a[0] ? wb_data : id_ex_sra);
    op_b_fwd = fwd_b[1] ? execute_out_q : (fwd_b[0] ? wb_data : id_ex_srb);
    alu_a    = id_ex_alu_a_src ? id_ex_pc : op_a_fwd;
    alu_b    = id_ex_alu_b_src ? op_b_fwd : id_ex_imm32;
    shamt    = id_ex_alu_b_src ? op_b_fwd[4:0] : id_ex_shamt;
    case (id_ex_alu_op)
      ALU_ADD:    alu_res = alu_a + alu_b;
      ALU_SUB:    alu_res = alu_a - alu_b;
      ALU_SLL:    alu_res = alu_a << shamt;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:    alu_res = alu_a ^ alu_b;
      ALU_SRL:    alu_res = alu_a >> shamt;
      ALU_SRA:    alu_res = XLEN'($signed(alu_a) >>> shamt);
      ALU_OR:     alu_res = alu_a | alu_b;
      ALU_AND:    alu_res = alu_a & alu_b;
      ALU_PASS_B: alu_res = alu_b;
      default:    alu_res = '0;
    endcase
    case (id_ex_ex_out_sel)
      EX_OUT_IMM:    ex_out = id_ex_imm32;
      EX_OUT_PC_INC: ex_out = id_ex_pc_inc;
      default:       ex_out = alu_res;
    endcase
  end

  md_iter #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_md_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (id_ex_valid & id_ex_md_en),
    .flush  (ex_flush),
    .freeze (ext_stall),
    .op     (id_ex_md_op),
    .a      (op_a_fwd),
    .b      (op_b_fwd),
    .busy   (md_busy),
    .stall  (md_stall),
    .done   (md_done),
    .result (md_result)
  );

  assign ex_stall_req = md_stall;

  // Bubbles keep the data fields so EX/MEM forwarding stays valid while stalled.
  always_comb begin
    execute_out_d = execute_out_q;
    mem_data_d    = mem_data_q;
    pc_d          = pc_q;
    ctrl_d        = ctrl_q;
    if (!ext_stall) begin
      if (ex_flush || (md_stall && !md_done)) begin
        ctrl_d = bubble_ctrl(ctrl_q);
      end else begin
        execute_out_d = md_done ? md_result : ex_out;
        mem_data_d    = op_b_fwd;
        pc_d          = id_ex_pc;
        ctrl_d        = id_ex_valid ? id_ex_ctrl : bubble_ctrl(id_ex_ctrl);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      execute_out_q <= '0;
      mem_data_q    <= '0;
      pc_q          <= '0;
      ctrl_q        <= '0;
    end else begin
      execute_out_q <= execute_out_d;
      mem_data_q    <= mem_data_d;
      pc_q          <= pc_d;
      ctrl_q        <= ctrl_d;
    end
  end

  assign ex_mem_execute_out = execute_out_q;
  assign ex_mem_mem_data_in = mem_data_q;
  assign ex_mem_pc          = pc_q;
  assign ex_mem_ctrl        = ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_execute_md_stage.sv
// +--------------------------------------------------------------------------+
// | tb_execute_md_stage : directed self-checking bench for execute_md_stage |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_execute_md_stage;
  import execute_md_stage_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         id_ex_valid;
  ex_ctrl_t     id_ex_ctrl;
  alu_t         id_ex_alu_op;
  logic         id_ex_md_en;
  md_op_t       id_ex_md_op;
  logic         id_ex_alu_a_src;
  logic         id_ex_alu_b_src;
  logic [4:0]   id_ex_shamt;
  execute_mux_t id_ex_ex_out_sel;
  logic [31:0]  id_ex_sra, id_ex_srb, id_ex_imm32, id_ex_pc, id_ex_pc_inc;
  logic [1:0]   fwd_a, fwd_b;
  logic [31:0]  wb_data;
  logic         ext_stall;
  logic         ex_flush;
  logic         ex_stall_req;
  logic         md_busy;
  logic [31:0]  ex_mem_execute_out, ex_mem_mem_data_in, ex_mem_pc;
  ex_ctrl_t     ex_mem_ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  execute_md_stage #(.XLEN(32), .MUL_BITS(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_ex_valid        (id_ex_valid),
    .id_ex_ctrl         (id_ex_ctrl),
    .id_ex_alu_op       (id_ex_alu_op),
    .id_ex_md_en        (id_ex_md_en),
    .id_ex_md_op        (id_ex_md_op),
    .id_ex_alu_a_src    (id_ex_alu_a_src),
    .id_ex_alu_b_src    (id_ex_alu_b_src),
    .id_ex_shamt        (id_ex_shamt),
    .id_ex_ex_out_sel   (id_ex_ex_out_sel),
    .id_ex_sra          (id_ex_sra),
    .id_ex_srb          (id_ex_srb),
    .id_ex_imm32        (id_ex_imm32),
    .id_ex_pc           (id_ex_pc),
    .id_ex_pc_inc       (id_ex_pc_inc),
    .fwd_a              (fwd_a),
    .fwd_b              (fwd_b),
    .wb_data            (wb_data),
    .ext_stall          (ext_stall),
    .ex_flush           (ex_flush),
    .ex_stall_req       (ex_stall_req),
    .md_busy            (md_busy),
    .ex_mem_execute_out (ex_mem_execute_out),
    .ex_mem_mem_data_in (ex_mem_mem_data_in),
    .ex_mem_pc          (ex_mem_pc),
    .ex_mem_ctrl        (ex_mem_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000 ns");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one M op and follow it until its result lands in EX/MEM.
  // ext_stall is raised for stall cycles [fa, fa+fl).
  task automatic run_md(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input logic [31:0] exp_res,
                        input logic [31:0] prev, input int fa, input int fl,
                        input string tag);
    int stalls;
    int bubbles;
    stalls  = 0;
    bubbles = 0;
    id_ex_valid = 1'b1;
    id_ex_md_en = 1'b1;
    id_ex_md_op = op;
    id_ex_sra   = a;
    id_ex_srb   = b;
    #1;
    while (ex_stall_req && stalls < 100) begin
      ext_stall = (stalls >= fa) && (stalls < fa + fl);
      stalls++;
      tick();
      if (ext_stall) check({tag, "_frozen_out"}, ex_mem_execute_out, prev);
      if (!ex_mem_ctrl.reg_write) bubbles++;
    end
    ext_stall = 1'b0;
    check({tag, "_stall_cycles"}, stalls, exp_stall);
    check({tag, "_bubbles"}, bubbles, exp_stall);
    check({tag, "_held_out"}, ex_mem_execute_out, prev);
    tick();
    check({tag, "_result"}, ex_mem_execute_out, exp_res);
    check({tag, "_reg_write"}, ex_mem_ctrl.reg_write, 1'b1);
    check({tag, "_busy_after"}, md_busy, 1'b0);
    id_ex_valid = 1'b0;
    id_ex_md_en = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    id_ex_valid      = 1'b0;
    id_ex_ctrl       = '0;
    id_ex_alu_op     = ALU_ADD;
    id_ex_md_en      = 1'b0;
    id_ex_md_op      = MD_MUL;
    id_ex_alu_a_src  = 1'b0;
    id_ex_alu_b_src  = 1'b1;
    id_ex_shamt      = 5'd0;
    id_ex_ex_out_sel = EX_OUT_ALU;
    id_ex_sra        = '0;
    id_ex_srb        = '0;
    id_ex_imm32      = '0;
    id_ex_pc         = 32'h100;
    id_ex_pc_inc     = 32'h104;
    fwd_a            = 2'b00;
    fwd_b            = 2'b00;
    wb_data          = '0;
    ext_stall        = 1'b0;
    ex_flush         = 1'b0;

    repeat (2) tick();
    check("rst_execute_out", ex_mem_execute_out, 32'h0);
    check("rst_ctrl", ex_mem_ctrl, '0);
    check("rst_stall_req", ex_stall_req, 1'b0);
    check("rst_busy", md_busy, 1'b0);
    rst_n = 1'b1;

    // Load 0xFFFFFFFD into EX/MEM via the IMM path for the forwarding test.
    id_ex_ctrl           = '0;
    id_ex_ctrl.reg_write = 1'b1;
    id_ex_ctrl.rd        = 5'd5;
    id_ex_valid          = 1'b1;
    id_ex_ex_out_sel     = EX_OUT_IMM;
    id_ex_imm32          = 32'hFFFF_FFFD;
    tick();
    check("imm_out", ex_mem_execute_out, 32'hFFFF_FFFD);
    check("imm_pc", ex_mem_pc, 32'h100);
    id_ex_ex_out_sel = EX_OUT_ALU;

    fwd_b = 2'b10;
    run_md(MD_MUL, 32'd7, 32'h0000_1234, 9, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 1000, 0, "mul_fwd");
    check("mul_fwd_store_data", ex_mem_mem_data_in, 32'hFFFF_FFFD);
    fwd_b = 2'b00;

    run_md(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 9,  32'hFFFF_FFFE, 32'hFFFF_FFEB, 1000, 0, "mulhu");
    run_md(MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         9,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1000, 0, "mulhsu");
    run_md(MD_DIV,    32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1000, 0, "div");
    run_md(MD_REM,    32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1000, 0, "rem");
    run_md(MD_DIV,    32'd10,        32'd0,         1,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1000, 0, "div_by0");
    run_md(MD_REMU,   32'd10,        32'd0,         1,  32'd10,        32'hFFFF_FFFF, 1000, 0, "remu_by0");
    run_md(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000, 32'd10,        1000, 0, "div_ovf");
    run_md(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1,  32'd0,         32'h8000_0000, 1000, 0, "rem_ovf");

    // 100 / 7 = 14 with a 5-cycle freeze in the middle of the iterations.
    run_md(MD_DIV, 32'd100, 32'd7, 38, 32'd14, 32'd0, 10, 5, "div_frz");

    // Flush after 12 DIV iterations.
    id_ex_valid = 1'b1;
    id_ex_md_en = 1'b1;
    id_ex_md_op = MD_DIV;
    id_ex_sra   = 32'd1000;
    id_ex_srb   = 32'd3;
    #1;
    repeat (13) tick();
    check("flush_busy_before", md_busy, 1'b1);
    ex_flush = 1'b1;
    tick();
    ex_flush    = 1'b0;
    id_ex_valid = 1'b0;
    id_ex_md_en = 1'b0;
    #1;
    check("flush_busy_after", md_busy, 1'b0);
    check("flush_reg_write", ex_mem_ctrl.reg_write, 1'b0);
    check("flush_out_held", ex_mem_execute_out, 32'd14);
    check("flush_stall_req", ex_stall_req, 1'b0);

    // Asynchronous reset in the middle of a MUL.
    id_ex_valid = 1'b1;
    id_ex_md_en = 1'b1;
    id_ex_md_op = MD_MUL;
    id_ex_sra   = 32'd5;
    id_ex_srb   = 32'd6;
    #1;
    repeat (3) tick();
    check("arst_busy_before", md_busy, 1'b1);
    id_ex_valid = 1'b0;
    id_ex_md_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_execute_out", ex_mem_execute_out, 32'h0);
    check("arst_mem_data", ex_mem_mem_data_in, 32'h0);
    check("arst_pc", ex_mem_pc, 32'h0);
    check("arst_ctrl", ex_mem_ctrl, '0);
    check("arst_stall_req", ex_stall_req, 1'b0);
    check("arst_busy", md_busy, 1'b0);
    rst_n = 1'b1;

    // ADD 3 + 4 straight after reset release.
    id_ex_valid     = 1'b1;
    id_ex_alu_op    = ALU_ADD;
    id_ex_alu_a_src = 1'b0;
    id_ex_alu_b_src = 1'b1;
    id_ex_sra       = 32'd3;
    id_ex_srb       = 32'd4;
    tick();
    check("add_after_rst", ex_mem_execute_out, 32'd7);
    check("add_reg_write", ex_mem_ctrl.reg_write, 1'b1);

    // Forwarding priority: EX/MEM over WB.
    fwd_a   = 2'b11;
    wb_data = 32'd100;
    tick();
    check("fwd_exmem_prio", ex_mem_execute_out, 32'd11);
    fwd_a = 2'b01;
    tick();
    check("fwd_wb", ex_mem_execute_out, 32'd104);

    // SRA by immediate shift amount.
    fwd_a           = 2'b00;
    id_ex_alu_op    = ALU_SRA;
    id_ex_alu_b_src = 1'b0;
    id_ex_shamt     = 5'd4;
    id_ex_sra       = 32'h8000_0000;
    tick();
    check("sra_imm", ex_mem_execute_out, 32'hF800_0000);

    id_ex_ex_out_sel = EX_OUT_PC_INC;
    id_ex_pc_inc     = 32'h44;
    tick();
    check("pc_inc_sel", ex_mem_execute_out, 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
